scoreboard: RTL and testbench
=============================

SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, architectural register count; register 0 is hardwired zero.
REQ-002 SHALL have parameter NRD, default 2, source-operand read ports checked per issue.
REQ-003 SHALL have parameter NWB, default 2, writeback ports.
REQ-004 SHALL have parameter CNT_W, default 2, per-register pending-write counter width; max in-flight per register = 2^CNT_W-1.
REQ-005 SHALL derive AW = clog2(NREG) and TOT_W = clog2(NREG*2^CNT_W)+1.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 issue_valid  in  1  decode presents an instruction.
REQ-009 issue_wen  in  1  instruction writes a destination register.
REQ-010 issue_dst  in  AW  destination register.
REQ-011 issue_src  in  NRD*AW  source registers, port i at bits [i*AW +: AW].
REQ-012 issue_ready  out  1  instruction may issue this cycle; issue fires on issue_valid & issue_ready.
REQ-013 wb_valid  in  NWB  per-port writeback strobe.
REQ-014 wb_dst  in  NWB*AW  per-port writeback register.
REQ-015 flush  in  1  squash all in-flight writes.
REQ-016 busy  out  NREG  bit r = 1 when register r counter is nonzero (registered).
REQ-017 inflight  out  TOT_W  sum of all counters (registered).
REQ-018 err  out  1  sticky underflow/overflow flag.

Function
REQ-019 issue_ready SHALL be 0 when any issue_src equals a nonzero register with busy=1 (RAW), except as REQ-030 permits.
REQ-020 issue_ready SHALL be 0 when issue_wen=1, issue_dst!=0 and that counter equals 2^CNT_W-1.
REQ-021 issue_ready SHALL be 1 otherwise; it SHALL NOT depend on issue_valid.
REQ-022 On fire with issue_wen=1 and issue_dst!=0, the counter SHALL increment on the next edge.
REQ-023 Each wb_valid[k] with wb_dst[k]!=0 SHALL decrement that counter by 1 on the next edge; multiple ports hitting one register SHALL decrement by the number of hits.
REQ-024 Simultaneous issue and writeback to the same register SHALL apply net change (+1 − hits) in one cycle.
REQ-025 A decrement below zero SHALL clamp the counter at 0 and set err.
REQ-026 Register 0 SHALL never be tracked: busy[0]=0, counter held 0, never a hazard.
REQ-027 inflight SHALL equal the sum of counters after each edge, updated in the same cycle as counters.
REQ-028 flush SHALL clear all counters and inflight on the next edge; issue and writeback in the flush cycle SHALL be ignored; err unchanged.
REQ-029 err SHALL remain 1 until reset.

Reset
REQ-030 While reset=1: all counters 0, busy=0, inflight=0, err=0, issue_ready=1 for any sources; reset mid-operation SHALL discard all pending state immediately without waiting for a clock edge.

Configuration
REQ-031 Macro SCOREBOARD_WB_BYPASS_EN: when defined, a source whose counter is 1 and which receives exactly one writeback hit this cycle SHALL NOT block issue_ready (combinational wb-to-ready path); when undefined, the source blocks until busy clears on the following edge (one extra stall cycle), and issue_ready SHALL depend only on registered state and issue inputs.

Verification
REQ-032 Reset, issue x5 wen -> next cycle busy[5]=1, inflight=1; issue src x5 -> issue_ready=0.
REQ-033 x5 counter 1, wb_valid[0] wb_dst=5 with src x5 presented -> with macro issue_ready=1 same cycle; without macro issue_ready=0, then 1 next cycle.
REQ-034 CNT_W=2: three issues to x7 with no writeback -> counter 3, fourth issue to x7 issue_ready=0; one wb x7 -> counter 2, issue_ready=1.
REQ-035 x3 counter 2, wb ports 0 and 1 both x3 plus issue to x3 same cycle -> counter 1, inflight reduced by 1.
REQ-036 wb x9 with counter 0 -> counter stays 0, err=1 and stays 1 after flush; reset clears it.
REQ-037 inflight=4 across x1,x2,x4, flush with concurrent issue x6 -> next cycle inflight=0, busy all 0; issue/wen on x0 -> busy[0]=0, inflight=0.

Source files
------------

// File: rtl/scoreboard.sv
// Register scoreboard: per-register pending-write counters gate issue on RAW hazards and counter saturation.
// issue_ready is combinational from registered counters (plus same-cycle writebacks with SCOREBOARD_WB_BYPASS_EN); counters/busy/inflight update on the next edge.
// Backpressure: issue_ready low stalls decode; writebacks and flush are always accepted.
module scoreboard #(
  parameter int NREG  = 32,
  parameter int NRD   = 2,
  parameter int NWB   = 2,
  parameter int CNT_W = 2,
  localparam int AW    = $clog2(NREG),
  localparam int TOT_W = $clog2(NREG * (2 ** CNT_W)) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_wen,
  input  logic [AW-1:0]     issue_dst,
  input  logic [NRD*AW-1:0] issue_src,
  output logic              issue_ready,
  input  logic [NWB-1:0]    wb_valid,
  input  logic [NWB*AW-1:0] wb_dst,
  input  logic              flush,
  output logic [NREG-1:0]   busy,
  output logic [TOT_W-1:0]  inflight,
  output logic              err
);

  localparam int HW       = $clog2(NWB + 1);
  localparam int CNT_MAX  = (2 ** CNT_W) - 1;

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0][HW-1:0]    hits;
  logic [TOT_W-1:0]           inflight_q, inflight_d;
  logic                       err_q, err_d;
  logic                       fire;

  // Writeback hits per register; several ports may target the same register.
  always_comb begin
    hits = '0;
    for (int k = 0; k < NWB; k++) begin
      if (wb_valid[k] && (wb_dst[k*AW +: AW] != '0)) begin
        hits[wb_dst[k*AW +: AW]] = hits[wb_dst[k*AW +: AW]] + HW'(1);
      end
    end
  end

  always_comb begin
    logic [AW-1:0] src;
    src         = '0;
    issue_ready = 1'b1;
    for (int i = 0; i < NRD; i++) begin
      src = issue_src[i*AW +: AW];
      if ((src != '0) && (cnt_q[src] != '0)) begin
`ifdef SCOREBOARD_WB_BYPASS_EN
        // Last outstanding write retiring this cycle: its value is on the bypass network.
        if (!((cnt_q[src] == CNT_W'(1)) && (hits[src] == HW'(1)))) begin
          issue_ready = 1'b0;
        end
`else
        issue_ready = 1'b0;
`endif
      end
    end
    if (issue_wen && (issue_dst != '0) && (cnt_q[issue_dst] == CNT_W'(CNT_MAX))) begin
      issue_ready = 1'b0;
    end
    if (reset) begin
      issue_ready = 1'b1;
    end
  end

  assign fire = issue_valid & issue_ready;

  always_comb begin
    int net;
    int tot;
    net   = 0;
    tot   = 0;
    cnt_d = cnt_q;
    err_d = err_q;
    for (int r = 1; r < NREG; r++) begin
      net = int'(cnt_q[r]) - int'(hits[r]);
      if (fire && issue_wen && (int'(issue_dst) == r)) begin
        net = net + 1;
      end
      if (net < 0) begin
        net   = 0;
        err_d = 1'b1;
      end else if (net > CNT_MAX) begin
        net   = CNT_MAX;
        err_d = 1'b1;
      end
      cnt_d[r] = CNT_W'(net);
    end
    cnt_d[0] = '0;
    if (flush) begin
      cnt_d = '0;
      err_d = err_q;
    end
    for (int r = 0; r < NREG; r++) begin
      tot = tot + int'(cnt_d[r]);
    end
    inflight_d = TOT_W'(tot);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      busy[r] = |cnt_q[r];
    end
  end

  assign inflight = inflight_q;
  assign err      = err_q;

endmodule

// File: tb/tb_scoreboard.sv
// Randomized and directed bench for scoreboard against a counter-array model of pending writes.
module tb_scoreboard;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic        issue_wen;
  logic [4:0]  issue_dst;
  logic [9:0]  issue_src;
  logic        issue_ready;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_dst;
  logic        flush;
  logic [31:0] busy;
  logic [7:0]  inflight;
  logic        err;

  scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_dst(issue_dst),
    .issue_src(issue_src), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .flush(flush),
    .busy(busy), .inflight(inflight), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  int   m_cnt[32];
  logic m_err;
  logic last_rdy;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int nhits(int r);
    int n = 0;
    if (r != 0) begin
      if (wb_valid[0] && int'(wb_dst[4:0]) == r) n++;
      if (wb_valid[1] && int'(wb_dst[9:5]) == r) n++;
    end
    return n;
  endfunction

  function automatic logic src_blocks(int s);
    if (s == 0 || m_cnt[s] == 0) return 1'b0;
    if (BYPASS && m_cnt[s] == 1 && nhits(s) == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic model_ready();
    if (src_blocks(int'(issue_src[4:0])) || src_blocks(int'(issue_src[9:5]))) return 1'b0;
    if (issue_wen && issue_dst != 0 && m_cnt[int'(issue_dst)] == 3) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  function automatic int model_total();
    int t = 0;
    for (int r = 0; r < 32; r++) t += m_cnt[r];
    return t;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 1'b0;
  endtask

  task automatic model_update(input logic fired);
    int nc[32];
    if (flush) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      return;
    end
    for (int r = 0; r < 32; r++) begin
      nc[r] = m_cnt[r] - nhits(r);
      if (fired && issue_wen && r != 0 && int'(issue_dst) == r) nc[r]++;
      if (nc[r] < 0) begin nc[r] = 0; m_err = 1'b1; end
    end
    for (int r = 0; r < 32; r++) m_cnt[r] = nc[r];
  endtask

  task automatic step(input logic v, input logic wen, input int dst, input int s0, input int s1,
                      input logic wv0, input int wd0, input logic wv1, input int wd1, input logic fl);
    logic exp_rdy;
    issue_valid = v;
    issue_wen   = wen;
    issue_dst   = 5'(dst);
    issue_src   = {5'(s1), 5'(s0)};
    wb_valid    = {wv1, wv0};
    wb_dst      = {5'(wd1), 5'(wd0)};
    flush       = fl;
    #1;
    exp_rdy  = model_ready();
    last_rdy = issue_ready;
    chk("issue_ready", {31'b0, issue_ready}, {31'b0, exp_rdy});
    chk("busy", busy, model_busy());
    chk("inflight", {24'b0, inflight}, 32'(model_total()));
    chk("err", {31'b0, err}, {31'b0, m_err});
    @(posedge clk);
    model_update(v && exp_rdy);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  // Asserted away from the clock edge: state must clear without an edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_busy", busy, 32'h0);
    chk("rst_inflight", {24'b0, inflight}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_ready", {31'b0, issue_ready}, 32'h1);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; issue_valid = 0; issue_wen = 0; issue_dst = 0; issue_src = 0;
    wb_valid = 0; wb_dst = 0; flush = 0;
    model_clear();
    do_reset();

    // RAW on x5
    step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    chk("x5_ready", {31'b0, last_rdy}, 32'h0);
    chk("x5_busy", {31'b0, busy[5]}, 32'h1);
    chk("x5_inflight", {24'b0, inflight}, 32'h1);

    // Writeback to x5 with x5 as source
    step(1, 0, 0, 5, 0, 1, 5, 0, 0, 0);
    chk("bypass_ready", {31'b0, last_rdy}, {31'b0, BYPASS});
    step(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    chk("after_wb_ready", {31'b0, last_rdy}, 32'h1);

    // Counter saturation on x7
    repeat (3) step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    chk("x7_full_ready", {31'b0, last_rdy}, 32'h0);
    chk("x7_inflight", {24'b0, inflight}, 32'h3);
    step(0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    chk("x7_drain_ready", {31'b0, last_rdy}, 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Double writeback plus issue on x3
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 0, 0, 1, 3, 1, 3, 0);
    chk("x3_inflight", {24'b0, inflight}, 32'h1);
    chk("x3_busy", {31'b0, busy[3]}, 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Underflow on x9, sticky through flush
    step(0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("uf_err", {31'b0, err}, 32'h1);
    chk("uf_inflight", {24'b0, inflight}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("uf_err_flush", {31'b0, err}, 32'h1);
    do_reset();

    // Flush with concurrent issue, then x0 writes
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_flush_inflight", {24'b0, inflight}, 32'h4);
    step(1, 1, 6, 0, 0, 0, 0, 0, 0, 1);
    chk("flush_inflight", {24'b0, inflight}, 32'h0);
    chk("flush_busy", busy, 32'h0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_busy", busy, 32'h0);
    chk("x0_inflight", {24'b0, inflight}, 32'h0);

    // Mid-operation reset with live state
    step(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
    issue_src = {5'd0, 5'd8};
    do_reset();

    // Randomized traffic on a small register window to provoke hazards
    for (int c = 0; c < 800; c++) begin
      if (c % 200 == 199) begin
        do_reset();
      end else begin
        step(($urandom % 4) != 0, $urandom % 2, $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7),
             ($urandom % 3) == 0, $urandom_range(0, 7),
             ($urandom % 4) == 0, $urandom_range(0, 7),
             ($urandom % 50) == 0);
      end
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
